// File: rtl/cc_pkg.sv
// ============================================================================
// Module  : cc_pkg
// Brief   : Shared state encoding and direction constants for the load counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cc_state_t;

  localparam logic CC_DIR_UP = 1'b1;
  localparam logic CC_DIR_DN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/cc_step.sv
// ============================================================================
// Module  : cc_step
// Brief   : Combinational up/down successor with terminal-count detection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cc_step
  import cc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WRAP  = 1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  output logic [WIDTH-1:0] next_q,
  output logic             is_term
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    is_term = (dir == CC_DIR_UP) ? (&q) : (~|q);
    next_q  = (dir == CC_DIR_UP) ? (q + ONE) : (q - ONE);
    // Without wrap the counter parks on the terminal value.
    if (is_term && (WRAP == 0)) begin
      next_q = q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cc_load_counter.sv
// ============================================================================
// Module  : cc_load_counter
// Brief   : Loadable up/down counter with IDLE/RUN/DONE control and TC pulse.
//           Optional macro CC_LOAD_COUNTER_PARITY_EN adds registered par_pad.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cc_load_counter
  import cc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WRAP  = 1
) (
  input  logic             clk_pad,
  input  logic             rst_pad,
  input  logic             en_pad,
  input  logic             ld_valid_pad,
  output logic             ld_ready_pad,
  input  logic [WIDTH-1:0] ld_data_pad,
  input  logic             dir_pad,
  input  logic             cnt_en_pad,
  input  logic             stop_pad,
  output logic [WIDTH-1:0] q_pad,
  output logic             tc_pad,
  output logic             run_pad
`ifdef CC_LOAD_COUNTER_PARITY_EN
  ,
  output logic             par_pad
`endif
);

  cc_state_t        state;
  cc_state_t        state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] step_q;
  logic             step_term;
  logic             load;

  cc_step #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_step (
    .q       (q_pad),
    .dir     (dir_pad),
    .next_q  (step_q),
    .is_term (step_term)
  );

  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      state   <= IDLE;
      q_pad   <= '0;
      tc_pad  <= 1'b0;
      run_pad <= 1'b0;
    end else begin
      state   <= state_nxt;
      q_pad   <= q_nxt;
      tc_pad  <= tc_nxt;
      run_pad <= (state_nxt == RUN);
    end
  end

`ifdef CC_LOAD_COUNTER_PARITY_EN
  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      par_pad <= 1'b0;
    end else begin
      par_pad <= ^q_nxt;
    end
  end
`endif

  // Priority: enable-low clear, then load, then stop, then count.
  always_comb begin
    state_nxt = state;
    q_nxt     = q_pad;
    tc_nxt    = 1'b0;
    load      = ld_valid_pad & ld_ready_pad;
    if (!en_pad) begin
      state_nxt = IDLE;
      q_nxt     = '0;
    end else if (load) begin
      state_nxt = RUN;
      q_nxt     = ld_data_pad;
    end else if (state == RUN) begin
      if (stop_pad) begin
        state_nxt = IDLE;
      end else if (cnt_en_pad) begin
        q_nxt  = step_q;
        tc_nxt = step_term;
        if (step_term && (WRAP == 0)) begin
          state_nxt = DONE;
        end
      end
    end
  end

  always_comb begin
    ld_ready_pad = en_pad & (state != RUN);
  end

endmodule

`default_nettype wire

// File: tb/tb_cc_load_counter.sv
// ============================================================================
// Module  : tb_cc_load_counter
// Brief   : Directed scoreboard bench driving a wrapping and a stopping
//           instance from the same stimulus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cc_load_counter;

  logic       clk_pad = 1'b0;
  logic       rst_pad;
  logic       en_pad;
  logic       ld_valid_pad;
  logic [7:0] ld_data_pad;
  logic       dir_pad;
  logic       cnt_en_pad;
  logic       stop_pad;

  logic       rdy_w, tc_w, run_w;
  logic [7:0] q_w;
  logic       rdy_s, tc_s, run_s;
  logic [7:0] q_s;
`ifdef CC_LOAD_COUNTER_PARITY_EN
  logic       par_w, par_s;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [7:0] qw;
    logic       tcw, runw, rdyw;
    logic [7:0] qs;
    logic       tcs, runs, rdys;
  } exp_t;

  exp_t sb[$];

  always #5 clk_pad = ~clk_pad;

  cc_load_counter #(.WIDTH(8), .WRAP(1)) u_wrap (
    .clk_pad      (clk_pad),
    .rst_pad      (rst_pad),
    .en_pad       (en_pad),
    .ld_valid_pad (ld_valid_pad),
    .ld_ready_pad (rdy_w),
    .ld_data_pad  (ld_data_pad),
    .dir_pad      (dir_pad),
    .cnt_en_pad   (cnt_en_pad),
    .stop_pad     (stop_pad),
    .q_pad        (q_w),
    .tc_pad       (tc_w),
    .run_pad      (run_w)
`ifdef CC_LOAD_COUNTER_PARITY_EN
    ,
    .par_pad      (par_w)
`endif
  );

  cc_load_counter #(.WIDTH(8), .WRAP(0)) u_stop (
    .clk_pad      (clk_pad),
    .rst_pad      (rst_pad),
    .en_pad       (en_pad),
    .ld_valid_pad (ld_valid_pad),
    .ld_ready_pad (rdy_s),
    .ld_data_pad  (ld_data_pad),
    .dir_pad      (dir_pad),
    .cnt_en_pad   (cnt_en_pad),
    .stop_pad     (stop_pad),
    .q_pad        (q_s),
    .tc_pad       (tc_s),
    .run_pad      (run_s)
`ifdef CC_LOAD_COUNTER_PARITY_EN
    ,
    .par_pad      (par_s)
`endif
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag,
                      input logic [7:0] qw, input logic tcw, input logic runw, input logic rdyw,
                      input logic [7:0] qs, input logic tcs, input logic runs, input logic rdys);
    exp_t e;
    e.tag = tag;
    e.qw = qw; e.tcw = tcw; e.runw = runw; e.rdyw = rdyw;
    e.qs = qs; e.tcs = tcs; e.runs = runs; e.rdys = rdys;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk8({e.tag, ".wrap.q"},   q_w,   e.qw);
    chk1({e.tag, ".wrap.tc"},  tc_w,  e.tcw);
    chk1({e.tag, ".wrap.run"}, run_w, e.runw);
    chk1({e.tag, ".wrap.rdy"}, rdy_w, e.rdyw);
    chk8({e.tag, ".stop.q"},   q_s,   e.qs);
    chk1({e.tag, ".stop.tc"},  tc_s,  e.tcs);
    chk1({e.tag, ".stop.run"}, run_s, e.runs);
    chk1({e.tag, ".stop.rdy"}, rdy_s, e.rdys);
`ifdef CC_LOAD_COUNTER_PARITY_EN
    chk1({e.tag, ".wrap.par"}, par_w, ^e.qw);
    chk1({e.tag, ".stop.par"}, par_s, ^e.qs);
`endif
  endtask

  // Inputs are set at the falling edge; results are sampled 1 time unit after the rising edge.
  task automatic cyc(input string tag,
                     input logic [7:0] qw, input logic tcw, input logic runw, input logic rdyw,
                     input logic [7:0] qs, input logic tcs, input logic runs, input logic rdys);
    push(tag, qw, tcw, runw, rdyw, qs, tcs, runs, rdys);
    @(posedge clk_pad);
    #1;
    pop_check();
    @(negedge clk_pad);
  endtask

  task automatic drive(input logic en, input logic vld, input logic [7:0] d,
                       input logic dir, input logic cnt, input logic stp);
    en_pad = en; ld_valid_pad = vld; ld_data_pad = d;
    dir_pad = dir; cnt_en_pad = cnt; stop_pad = stp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_pad = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #12;
    push("reset", 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    pop_check();
    @(negedge clk_pad);
    rst_pad = 1'b0;

    cyc("idle", 8'h00, 0, 0, 1, 8'h00, 0, 0, 1);

    // Up count through the all-ones terminal.
    drive(1, 1, 8'hFD, 1, 1, 0);
    cyc("load_fd", 8'hFD, 0, 1, 0, 8'hFD, 0, 1, 0);
    drive(1, 0, 8'h00, 1, 1, 0);
    cyc("up_fe", 8'hFE, 0, 1, 0, 8'hFE, 0, 1, 0);
    cyc("up_ff", 8'hFF, 0, 1, 0, 8'hFF, 0, 1, 0);
    cyc("up_term", 8'h00, 1, 1, 0, 8'hFF, 1, 0, 1);
    cyc("up_after", 8'h01, 0, 1, 0, 8'hFF, 0, 0, 1);

    // Enable low clears both and blocks loads.
    drive(0, 1, 8'hAA, 1, 1, 0);
    cyc("en_low", 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

    // Down count through zero.
    drive(1, 1, 8'h02, 0, 1, 0);
    cyc("load_02", 8'h02, 0, 1, 0, 8'h02, 0, 1, 0);
    drive(1, 0, 8'h00, 0, 1, 0);
    cyc("dn_01", 8'h01, 0, 1, 0, 8'h01, 0, 1, 0);
    cyc("dn_00", 8'h00, 0, 1, 0, 8'h00, 0, 1, 0);
    cyc("dn_term", 8'hFF, 1, 1, 0, 8'h00, 1, 0, 1);
    cyc("dn_after", 8'hFE, 0, 1, 0, 8'h00, 0, 0, 1);

    // Load while running is held off; DONE accepts it.
    drive(1, 1, 8'h55, 0, 1, 0);
    cyc("pend_55", 8'hFD, 0, 1, 0, 8'h55, 0, 1, 0);
    drive(1, 1, 8'h55, 0, 1, 1);
    cyc("stop", 8'hFD, 0, 0, 1, 8'h55, 0, 0, 1);
    drive(1, 1, 8'h55, 0, 1, 0);
    cyc("load_55", 8'h55, 0, 1, 0, 8'h55, 0, 1, 0);
    drive(1, 0, 8'h00, 1, 0, 0);
    cyc("hold", 8'h55, 0, 1, 0, 8'h55, 0, 1, 0);
    drive(1, 0, 8'h00, 1, 1, 0);
    cyc("up_56", 8'h56, 0, 1, 0, 8'h56, 0, 1, 0);

    // Enable drop mid-run at 8'h40.
    drive(1, 0, 8'h00, 1, 1, 1);
    cyc("stop2", 8'h56, 0, 0, 1, 8'h56, 0, 0, 1);
    drive(1, 1, 8'h3F, 1, 1, 0);
    cyc("load_3f", 8'h3F, 0, 1, 0, 8'h3F, 0, 1, 0);
    drive(1, 0, 8'h00, 1, 1, 0);
    cyc("up_40", 8'h40, 0, 1, 0, 8'h40, 0, 1, 0);
    drive(0, 0, 8'h00, 1, 1, 0);
    cyc("en_drop", 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

    // Asynchronous reset mid-run.
    drive(1, 1, 8'h10, 1, 1, 0);
    cyc("load_10", 8'h10, 0, 1, 0, 8'h10, 0, 1, 0);
    drive(1, 0, 8'h00, 1, 1, 0);
    cyc("up_11", 8'h11, 0, 1, 0, 8'h11, 0, 1, 0);
    #2;
    rst_pad = 1'b1;
    #1;
    push("async_rst", 8'h00, 0, 0, 1, 8'h00, 0, 0, 1);
    pop_check();
    @(negedge clk_pad);
    rst_pad = 1'b0;
    cyc("post_rst", 8'h00, 0, 0, 1, 8'h00, 0, 0, 1);

    // Parity walk 07 -> 08 -> 09.
    drive(1, 1, 8'h07, 1, 1, 0);
    cyc("load_07", 8'h07, 0, 1, 0, 8'h07, 0, 1, 0);
    drive(1, 0, 8'h00, 1, 1, 0);
    cyc("up_08", 8'h08, 0, 1, 0, 8'h08, 0, 1, 0);
    cyc("up_09", 8'h09, 0, 1, 0, 8'h09, 0, 1, 0);

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
